uart_status_tx: RTL

UART 8N1 transmitter with a small byte FIFO, the outbound counterpart to the `uart_echo` receive path. Game logic pushes status bytes, such as state changes, hits and score events, into the FIFO from the 25 MHz pixel-clock domain. The block serialises them on `RsTx` to the host PC. It runs on the same `Pclk` as the sprite and VGA logic and needs no clock-domain crossing.

---
 rtl/uart_status_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_status_tx.sv
// uart_status_tx: byte FIFO feeding a UART transmitter, all on Pclk.
// Default frame is 8N1. Define UART_STATUS_TX_PARITY_EN to insert an even
// parity bit between the last data bit and the stop bit (8E1).
// Each frame is loaded straight out of the FIFO, so a push never disturbs
// the byte already on the line.
module uart_status_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 2
) (
  input  logic       Pclk,
  input  logic       RESET,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       TX
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ZERO  = '0;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [15:0]        BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_STATUS_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, empty_q, ovf_q;
  logic               push, pop;

  // Transmitter state
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        bit_end;

  // full is the pre-edge flag, so a push while full is dropped even when a
  // pop happens on the same edge.
  assign push    = wr_en & ~full_q;
  assign bit_end = (baud_q == BAUD_LAST);

  // Occupancy next-state; full/empty are registered from it.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset discards contents by clearing pointers.
  always_ff @(posedge Pclk or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == CNT_ZERO);
      ovf_q   <= ovf_q | (wr_en & full_q);
    end
  end

  // Data-only storage: FIFO entries and the byte in flight need no reset.
  always_ff @(posedge Pclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
    data_q <= data_d;
  end

  // Transmit FSM next-state and line value; TX is registered from tx_d.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_STATUS_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_STATUS_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!empty_q) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Transmit FSM registers; reset forces the line idle at once.
  always_ff @(posedge Pclk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign TX       = tx_q;

endmodule
